hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core: the block that drives the `en`/`flush` controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards and taken branches. It also sequences multi-cycle multiply/divide (MDU) occupancy of EX with a small FSM and countdown counter. It sits beside the decode stage and takes register fields and control bits from ID and EX.

## Interface
Parameters:
- `MDU_CYCLES`, 4 — total cycles an MDU instruction occupies EX; legal range ≥ 2.
- `CNT_W`, `$clog2(MDU_CYCLES)` — width of the MDU countdown counter.

Ports:
- `clk` in 1 — clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `id_rs` in 5 — rs field of the instruction in ID.
- `id_rt` in 5 — rt field of the instruction in ID.
- `id_uses_rt` in 1 — the ID instruction reads rt.
- `ex_rt` in 5 — destination (rt) of the instruction in EX.
- `ex_memread` in 1 — the EX instruction is a load.
- `ex_branch_taken` in 1 — a branch or jump resolved taken in EX.
- `ex_mdu_start` in 1 — the EX instruction is a multi-cycle MDU op; it stays high while that instruction is held in EX.
- `pc_en` out 1 — PC write enable.
- `ifid_en` out 1 — IF/ID enable.
- `ifid_flush` out 1 — IF/ID flush.
- `idex_en` out 1 — ID/EX enable.
- `idex_flush` out 1 — ID/EX flush (inserts a bubble).
- `exmem_flush` out 1 — EX/MEM flush.
- `mdu_busy` out 1 — FSM is in BUSY.
- `mdu_done` out 1 — one-cycle pulse on the final EX cycle of an MDU op.

## Operation
- **Registered state:**
  - FSM states are IDLE and BUSY.
  - `cnt[CNT_W-1:0]` is the countdown counter.
  - All outputs are combinational (Mealy) functions of the state, `cnt` and the inputs.
- **Default (no hazard):** all enables are 1 and all flushes are 0.
- **Load-use hazard** (IDLE only). Condition: `ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt))`.
  - Response: `pc_en=0`, `ifid_en=0`, `idex_flush=1`.
  - The load advances to MEM, so the hazard clears the next cycle without any state change.
- **Taken branch** (IDLE only):
  - Response: `ifid_flush=1`, `idex_flush=1`, `pc_en=1` (redirect).
  - Takes priority over a simultaneous load-use hazard; load-use stall outputs are suppressed.
- **MDU sequencing:**
  - IDLE with `ex_mdu_start && !ex_branch_taken`:
    - Outputs: `pc_en=0`, `ifid_en=0`, `idex_en=0`, `exmem_flush=1`.
    - Next state: if `MDU_CYCLES==2`, go to BUSY with `cnt=0`; otherwise go to BUSY with `cnt=MDU_CYCLES-2`.
  - BUSY with `cnt != 0`:
    - Outputs: same stall pattern as above.
    - Next state: `cnt` decrements.
    - Load-use and branch are ignored.
  - BUSY with `cnt == 0`:
    - Outputs: no stall, `mdu_done=1`.
    - Next state: IDLE.
    - `ex_mdu_start` is ignored in this cycle (it is still the same held instruction).
  - `mdu_busy = (state == BUSY)`.
- **Mutually exclusive inputs:** if both `ex_branch_taken` and `ex_mdu_start` are high in IDLE, the branch wins and the MDU start is ignored.

## Timing
- **Reset** (asynchronous, mid-operation included): state=IDLE, `cnt=0`. Outputs then follow IDLE logic, e.g. with all inputs 0 they are `pc_en=ifid_en=idex_en=1`, all flushes 0, `mdu_busy=0`, `mdu_done=0`.
- **Load-use and branch:** zero-latency, asserted in the same cycle as the condition, for exactly one cycle per occurrence.
- **MDU:**
  - Stall is asserted for exactly `MDU_CYCLES-1` consecutive cycles, starting in the cycle `ex_mdu_start` is first seen in IDLE.
  - `mdu_done` pulses in cycle `MDU_CYCLES-1` relative to that start cycle (start = 0).
  - A new MDU op may start in the cycle immediately after `mdu_done`.
- **Register 0:** `ex_rt == 0` never causes a stall.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - Adds output `stall_cycles[31:0]`, which increments every cycle `pc_en==0`.
  - Adds output `flush_events[31:0]`, which increments every cycle `ifid_flush==1`.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: both ports and both counters are absent.

## Test plan
- Load-use: `ex_memread=1`, `ex_rt=8`, `id_rs=8` -> that cycle `pc_en=0`, `ifid_en=0`, `idex_flush=1`; next cycle with `ex_memread=0` -> defaults.
- Zero register: `ex_memread=1`, `ex_rt=0`, `id_rs=0` -> no stall. `ex_rt=9`, `id_rt=9`, `id_uses_rt=0` -> no stall.
- Branch plus load-use in the same cycle -> `ifid_flush=1`, `idex_flush=1`, `pc_en=1`.
- `MDU_CYCLES=4`: `ex_mdu_start` held high from cycle 0 -> stall in cycles 0–2, `mdu_done=1` and no stall in cycle 3, IDLE in cycle 4. A load-use condition during cycle 1 produces no `idex_flush`.
- Reset asserted in BUSY at cycle 1 -> immediately `mdu_busy=0` and defaults; after release with `ex_mdu_start` high, a fresh 3-cycle stall begins.
- With `HAZARD_PERF_CNT_EN`: 1 load-use, 1 branch and one MDU op (`MDU_CYCLES=4`) -> `stall_cycles=4`, `flush_events=1`.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and MDU occupancy sequencing.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MDU_CYCLES = 4,
  parameter int CNT_W      = $clog2(MDU_CYCLES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_memread,
  input  logic        ex_branch_taken,
  input  logic        ex_mdu_start,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        mdu_busy,
  output logic        mdu_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load_use;

  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output and next-state signal gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mdu_done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (ex_mdu_start) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
          state_d     = BUSY;
          cnt_d       = CNT_W'(MDU_CYCLES - 2);
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      BUSY: begin
        // The MDU op owns EX here; branch and load-use inputs are stale and ignored.
        if (cnt_q != '0) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
          cnt_d       = cnt_q - CNT_W'(1);
        end else begin
          mdu_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mdu_busy = (state_q == BUSY);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_events_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (!pc_en)     stall_cycles_q <= stall_cycles_q + 32'd1;
      if (ifid_flush) flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-age reference model of the hazard rules.
module tb_hazard_ctrl;
  localparam int MDU_CYCLES = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, ex_branch_taken, ex_mdu_start;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, mdu_busy, mdu_done;

  int vectors = 0;
  int miscompares = 0;
  // 0 = no MDU op in EX; k >= 1 = k-th cycle of an op (start cycle is age 0 in IDLE)
  int age = 0;

  hazard_ctrl #(.MDU_CYCLES(MDU_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .ex_mdu_start(ex_mdu_start),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done)
  );

  always #5 clk = ~clk;

  // Output vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_flush mdu_busy mdu_done
  function automatic logic [7:0] outs();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, mdu_busy, mdu_done};
  endfunction

  localparam logic [7:0] O_DEFAULT = 8'b1101_0000;
  localparam logic [7:0] O_BRANCH  = 8'b1111_1000;
  localparam logic [7:0] O_LOADUSE = 8'b0001_1000;
  localparam logic [7:0] O_MDU_ST  = 8'b0000_0100;
  localparam logic [7:0] O_MDU_BSY = 8'b0000_0110;
  localparam logic [7:0] O_MDU_DN  = 8'b1101_0011;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_out();
    logic lu;
    lu = ex_memread && ex_rt != 0 &&
         (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    if (age == 0) begin
      if (ex_branch_taken)   return O_BRANCH;
      else if (ex_mdu_start) return O_MDU_ST;
      else if (lu)           return O_LOADUSE;
      else                   return O_DEFAULT;
    end
    return (age < MDU_CYCLES - 1) ? O_MDU_BSY : O_MDU_DN;
  endfunction

  function automatic int model_next();
    if (age == 0) return (ex_mdu_start && !ex_branch_taken) ? 1 : 0;
    return (age == MDU_CYCLES - 1) ? 0 : age + 1;
  endfunction

  // Drive one cycle of inputs, compare against the model, then advance the model at the edge.
  task automatic step(input string tag, input logic mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic br, input logic mdu);
    @(negedge clk);
    ex_memread = mr; ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_branch_taken = br; ex_mdu_start = mdu;
    #1;
    check(tag, outs(), model_out());
    @(posedge clk);
    age = model_next();
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_branch_taken = 0; ex_mdu_start = 0;
    #2 reset = 1'b1;
    #1 check(tag, outs(), O_DEFAULT);
    age = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_branch_taken = 0; ex_mdu_start = 0;
    #12;
    check("reset_state", outs(), O_DEFAULT);
    @(negedge clk);
    reset = 1'b0;

    // Load-use, then it clears
    step("loaduse_rs",   1, 5'd8, 5'd8, 5'd3, 0, 0, 0);
    step("loaduse_clear",0, 5'd8, 5'd8, 5'd3, 0, 0, 0);
    step("loaduse_rt",   1, 5'd7, 5'd1, 5'd7, 1, 0, 0);
    // Zero register and unused rt never stall
    step("zero_reg",     1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    step("rt_unused",    1, 5'd9, 5'd1, 5'd9, 0, 0, 0);
    // Branch beats load-use; branch beats MDU start
    step("branch_lu",    1, 5'd8, 5'd8, 5'd0, 0, 1, 0);
    step("branch_mdu",   0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    // MDU op held for MDU_CYCLES cycles, load-use in cycle 1 ignored
    step("mdu_c0",       0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    step("mdu_c1_lu",    1, 5'd8, 5'd8, 5'd0, 0, 0, 1);
    step("mdu_c2",       0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    step("mdu_c3_done",  0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    // Back-to-back MDU op right after done
    step("mdu2_c0",      0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    step("mdu2_c1",      0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    step("mdu2_c2",      0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    step("mdu2_c3_done", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    step("idle_after",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    // Reset while BUSY, then a fresh op
    step("rst_mdu_c0",   0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    pulse_reset("reset_in_busy");
    for (int c = 0; c < MDU_CYCLES + 1; c++)
      step("fresh_mdu", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1'(c < MDU_CYCLES));

    // Randomized traffic with occasional mid-run resets
    for (int i = 0; i < 400; i++) begin
      logic mdu;
      if ($urandom_range(0, 49) == 0) pulse_reset("rand_reset");
      mdu = (age != 0) ? 1'b1 : ($urandom_range(0, 6) == 0);
      step("random",
           1'($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 5) == 0),
           mdu);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
